// File: rtl/accum_cpu_core.sv
// ============================================================================
// Module   : accum_cpu_core
// Brief    : Parametrised accumulator CPU core with a req/ack single-port
//            memory interface. Optional macro ACCUM_INDIRECT_EN adds LOADI/JUMPI.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module accum_cpu_core #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = 'h100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] ac,
  output logic                  halted,
  output logic                  retire
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  localparam logic [3:0] c_op_load  = 4'b0001;
  localparam logic [3:0] c_op_store = 4'b0010;
  localparam logic [3:0] c_op_add   = 4'b0011;
  localparam logic [3:0] c_op_sub   = 4'b0100;
  localparam logic [3:0] c_op_and   = 4'b0101;
  localparam logic [3:0] c_op_or    = 4'b0110;
  localparam logic [3:0] c_op_halt  = 4'b0111;
  localparam logic [3:0] c_op_skip  = 4'b1000;
  localparam logic [3:0] c_op_jump  = 4'b1001;
  localparam logic [3:0] c_op_clear = 4'b1010;
`ifdef ACCUM_INDIRECT_EN
  localparam logic [3:0] c_op_loadi = 4'b1011;
  localparam logic [3:0] c_op_jumpi = 4'b1100;
`endif

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_RD     = 3'd2,
    S_EXEC   = 3'd3,
    S_WR     = 3'd4,
    S_HALT   = 3'd5
`ifdef ACCUM_INDIRECT_EN
    , S_IND  = 3'd6
`endif
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_pc, w_pc_nxt;
  logic [DW-1:0]   r_ac, w_ac_nxt;
  logic [DW-1:0]   r_ir, w_ir_nxt;
  logic [DW-1:0]   r_mbr, w_mbr_nxt;
  logic            r_req, r_we, r_halted, r_retire, w_retire_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic [DW-1:0]   r_wdata;
  logic            w_xfer, w_nxt_mem, w_skip;
  logic [3:0]      w_opcode;
  logic [1:0]      w_cond;
  logic [AW-1:0]   w_operand;

  assign w_xfer    = r_req & mem_ack;
  assign w_opcode  = r_ir[DW-1:DW-4];
  assign w_cond    = r_ir[DW-5:DW-6];
  assign w_operand = AW'(r_ir[DW-5:0]);

  always_comb begin
    w_skip = 1'b0;
    case (w_cond)
      2'b00:   w_skip = r_ac[DW-1];
      2'b01:   w_skip = (r_ac == '0);
      2'b10:   w_skip = !r_ac[DW-1] && (r_ac != '0);
      default: w_skip = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ac_nxt     = r_ac;
    w_ir_nxt     = r_ir;
    w_mbr_nxt    = r_mbr;
    w_retire_nxt = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_xfer) begin
          w_ir_nxt    = mem_rdata;
          w_pc_nxt    = r_pc + 1'b1;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        case (w_opcode)
          c_op_load, c_op_add, c_op_sub, c_op_and, c_op_or: w_state_nxt = S_RD;
`ifdef ACCUM_INDIRECT_EN
          c_op_loadi, c_op_jumpi: w_state_nxt = S_RD;
`endif
          c_op_store: w_state_nxt = S_WR;
          c_op_halt: begin
            // pc already points past the halt; back it up so it shows the halt address
            w_pc_nxt     = r_pc - 1'b1;
            w_state_nxt  = S_HALT;
            w_retire_nxt = 1'b1;
          end
          c_op_skip: begin
            if (w_skip) w_pc_nxt = r_pc + 1'b1;
            w_state_nxt  = S_FETCH;
            w_retire_nxt = 1'b1;
          end
          c_op_jump: begin
            w_pc_nxt     = w_operand;
            w_state_nxt  = S_FETCH;
            w_retire_nxt = 1'b1;
          end
          c_op_clear: begin
            w_ac_nxt     = '0;
            w_state_nxt  = S_FETCH;
            w_retire_nxt = 1'b1;
          end
          default: begin
            w_state_nxt  = S_FETCH;
            w_retire_nxt = 1'b1;
          end
        endcase
      end
      S_RD: begin
        if (w_xfer) begin
          w_mbr_nxt   = mem_rdata;
          w_state_nxt = S_EXEC;
`ifdef ACCUM_INDIRECT_EN
          if (w_opcode == c_op_jumpi) begin
            w_pc_nxt     = AW'(mem_rdata);
            w_state_nxt  = S_FETCH;
            w_retire_nxt = 1'b1;
          end else if (w_opcode == c_op_loadi) begin
            w_state_nxt = S_IND;
          end
`endif
        end
      end
`ifdef ACCUM_INDIRECT_EN
      S_IND: begin
        if (w_xfer) begin
          w_mbr_nxt   = mem_rdata;
          w_state_nxt = S_EXEC;
        end
      end
`endif
      S_EXEC: begin
        case (w_opcode)
          c_op_add: w_ac_nxt = r_ac + r_mbr;
          c_op_sub: w_ac_nxt = r_ac - r_mbr;
          c_op_and: w_ac_nxt = r_ac & r_mbr;
          c_op_or:  w_ac_nxt = r_ac | r_mbr;
          default:  w_ac_nxt = r_mbr;
        endcase
        w_state_nxt  = S_FETCH;
        w_retire_nxt = 1'b1;
      end
      S_WR: begin
        if (w_xfer) begin
          w_state_nxt  = S_FETCH;
          w_retire_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bus outputs are registered from the next state so they change only on the
  // edge that enters a memory state, and stay put while waiting for ack.
  always_comb begin
    w_nxt_mem  = 1'b0;
    w_addr_nxt = r_addr;
    case (w_state_nxt)
      S_FETCH: begin w_nxt_mem = 1'b1; w_addr_nxt = w_pc_nxt;  end
      S_RD:    begin w_nxt_mem = 1'b1; w_addr_nxt = w_operand; end
      S_WR:    begin w_nxt_mem = 1'b1; w_addr_nxt = w_operand; end
`ifdef ACCUM_INDIRECT_EN
      S_IND:   begin w_nxt_mem = 1'b1; w_addr_nxt = AW'(w_mbr_nxt); end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_ac     <= '0;
      r_ir     <= '0;
      r_mbr    <= '0;
      r_req    <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_halted <= 1'b0;
      r_retire <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ac     <= w_ac_nxt;
      r_ir     <= w_ir_nxt;
      r_mbr    <= w_mbr_nxt;
      r_halted <= (w_state_nxt == S_HALT);
      r_retire <= w_retire_nxt;
      // A completing transfer always forces one idle cycle before the next request
      r_req    <= w_nxt_mem && !w_xfer;
      r_we     <= w_nxt_mem && (w_state_nxt == S_WR);
      if (w_nxt_mem) begin
        r_addr  <= w_addr_nxt;
        r_wdata <= w_ac_nxt;
      end
    end
  end

  assign mem_req   = r_req;
  assign mem_we    = r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign pc        = r_pc;
  assign ac        = r_ac;
  assign halted    = r_halted;
  assign retire    = r_retire;

endmodule

`default_nettype wire

// File: tb/tb_accum_cpu_core.sv
// ============================================================================
// Module   : tb_accum_cpu_core
// Brief    : Directed self-checking bench for accum_cpu_core with a
//            latency-programmable memory model and a retire scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_accum_cpu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we, mem_ack;
  logic [11:0] mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata, ac;
  logic        halted, retire;

  accum_cpu_core dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pc(pc), .ac(ac), .halted(halted), .retire(retire)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [0:4095];
  logic        ld_en;
  logic [11:0] ld_addr;
  logic [15:0] ld_data;
  int          wait_cnt = 0;
  int          wr_delay;

  assign mem_rdata = mem[mem_addr];
  assign mem_ack   = mem_req && (!mem_we || (wait_cnt >= wr_delay));

  always @(posedge clk) begin
    if (ld_en) mem[ld_addr] <= ld_data;
    else if (mem_req && mem_ack && mem_we) mem[mem_addr] <= mem_wdata;
    wait_cnt <= (mem_req && !mem_ack) ? wait_cnt + 1 : 0;
  end

  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  typedef struct {
    logic [11:0] pc;
    logic [15:0] ac;
    int          gap;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   last_cyc = 0;
  int   ret_id = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mem_load(input logic [11:0] a, input logic [15:0] d);
    ld_addr = a;
    ld_data = d;
    ld_en   = 1'b1;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  task automatic push(input logic [11:0] p, input logic [15:0] a, input int g);
    exp_t e;
    e.pc  = p;
    e.ac  = a;
    e.gap = g;
    q.push_back(e);
  endtask

  // Waits for the next retire pulse, compares it with the oldest expectation,
  // then steps one cycle so the same pulse is never consumed twice.
  task automatic check_retire();
    int   n;
    exp_t e;
    n = 0;
    while (!retire && n < 60) begin
      @(negedge clk);
      n++;
    end
    ret_id++;
    check($sformatf("retire%0d_seen", ret_id), {31'd0, retire}, 32'd1);
    if (q.size() != 0) begin
      e = q.pop_front();
      check($sformatf("retire%0d_pc", ret_id), {20'd0, pc}, {20'd0, e.pc});
      check($sformatf("retire%0d_ac", ret_id), {16'd0, ac}, {16'd0, e.ac});
      if (e.gap >= 0) check($sformatf("retire%0d_cycles", ret_id), cyc - last_cyc, e.gap);
    end
    last_cyc = cyc;
    @(negedge clk);
    check($sformatf("retire%0d_single", ret_id), {31'd0, retire}, 32'd0);
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n    = 1'b1;
    last_cyc = 0;
  endtask

  task automatic check_halt(input logic [11:0] hpc, input logic [15:0] hac);
    int bad;
    bad = 0;
    for (int i = 0; i < 25; i++) begin
      if (mem_req || !halted || retire || pc !== hpc || ac !== hac) bad++;
      @(negedge clk);
    end
    check("halt_frozen_cycles_bad", bad, 0);
  endtask

  initial begin
    int n;
    rst_n    = 1'b0;
    ld_en    = 1'b0;
    ld_addr  = '0;
    ld_data  = '0;
    wr_delay = 0;
    repeat (2) @(negedge clk);

    // ---------------- program 1: ALU, store under slow memory, skip/jump, halt
    mem_load(12'h005, 16'h0007);
    mem_load(12'h008, 16'h0000);
    mem_load(12'h010, 16'hFFFF);
    mem_load(12'h011, 16'h0002);
    mem_load(12'h012, 16'h0001);
    mem_load(12'h013, 16'h00FF);
    mem_load(12'h014, 16'hFF00);
    mem_load(12'h015, 16'h1234);
    mem_load(12'h016, 16'h8000);
    mem_load(12'h100, 16'h1005);
    mem_load(12'h101, 16'h1010);
    mem_load(12'h102, 16'h3011);
    mem_load(12'h103, 16'hA000);
    mem_load(12'h104, 16'h4012);
    mem_load(12'h105, 16'h5013);
    mem_load(12'h106, 16'h6014);
    mem_load(12'h107, 16'h1015);
    mem_load(12'h108, 16'h2008);
    mem_load(12'h109, 16'h1016);
    mem_load(12'h10A, 16'h8000);
    mem_load(12'h10B, 16'h7000);
    mem_load(12'h10C, 16'h8800);
    mem_load(12'h10D, 16'hA000);
    mem_load(12'h10E, 16'h8400);
    mem_load(12'h10F, 16'h7000);
    mem_load(12'h110, 16'h8C00);
    mem_load(12'h111, 16'hF000);
    mem_load(12'h112, 16'h9118);
    mem_load(12'h118, 16'h7000);

    check("rst_req",    {31'd0, mem_req}, 32'd0);
    check("rst_we",     {31'd0, mem_we}, 32'd0);
    check("rst_addr",   {20'd0, mem_addr}, 32'd0);
    check("rst_pc",     {20'd0, pc}, 32'h100);
    check("rst_ac",     {16'd0, ac}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_retire", {31'd0, retire}, 32'd0);

    push(12'h101, 16'h0007, 5);
    push(12'h102, 16'hFFFF, 4);
    push(12'h103, 16'h0001, 4);
    push(12'h104, 16'h0000, 2);
    push(12'h105, 16'hFFFF, 4);
    push(12'h106, 16'h00FF, 4);
    push(12'h107, 16'hFFFF, 4);
    push(12'h108, 16'h1234, 4);
    push(12'h109, 16'h1234, 6);
    push(12'h10A, 16'h8000, 5);
    push(12'h10C, 16'h8000, 2);
    push(12'h10D, 16'h8000, 2);
    push(12'h10E, 16'h0000, 2);
    push(12'h110, 16'h0000, 2);
    push(12'h111, 16'h0000, 2);
    push(12'h112, 16'h0000, 2);
    push(12'h118, 16'h0000, 2);
    push(12'h118, 16'h0000, 2);
    wr_delay = 3;
    release_reset();

    for (int i = 0; i < 8; i++) check_retire();

    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int k = 0; k < 4; k++) begin
      check($sformatf("store_hold%0d", k),
            {3'd0, mem_req, mem_we, mem_addr, mem_wdata}, {3'd0, 1'b1, 1'b1, 12'h008, 16'h1234});
      @(negedge clk);
    end
    check("store_req_drop", {31'd0, mem_req}, 32'd0);
    check("store_mem8", {16'd0, mem[8]}, 32'h1234);

    for (int i = 0; i < 10; i++) check_retire();
    check("p1_halted", {31'd0, halted}, 32'd1);
    check_halt(12'h118, 16'h0000);

    // ---------------- program 2: reset during a stalled store, jump, halt
    wr_delay = 1000;
    rst_n = 1'b0;
    @(negedge clk);
    mem_load(12'h009, 16'h0000);
    mem_load(12'h100, 16'h1005);
    mem_load(12'h101, 16'h2009);
    mem_load(12'h102, 16'h9104);
    mem_load(12'h104, 16'h910A);
    mem_load(12'h10A, 16'h7000);
    release_reset();
    n = 0;
    while (!(mem_req && mem_we) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("stall_store_seen", {31'd0, mem_req & mem_we}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_req",    {31'd0, mem_req}, 32'd0);
    check("async_rst_we",     {31'd0, mem_we}, 32'd0);
    check("async_rst_pc",     {20'd0, pc}, 32'h100);
    check("async_rst_ac",     {16'd0, ac}, 32'd0);
    check("async_rst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    check("abandoned_store_mem9", {16'd0, mem[9]}, 32'd0);

    wr_delay = 0;
    push(12'h101, 16'h0007, 5);
    push(12'h102, 16'h0007, 3);
    push(12'h104, 16'h0007, 3);
    push(12'h10A, 16'h0007, 2);
    push(12'h10A, 16'h0007, 2);
    release_reset();
    check("req_low_first_cycle", {31'd0, mem_req}, 32'd0);
    n = 0;
    while (!mem_req && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("first_fetch_addr", {19'd0, mem_we, mem_addr}, {19'd0, 1'b0, 12'h100});
    for (int i = 0; i < 5; i++) check_retire();
    check("p2_mem9", {16'd0, mem[9]}, 32'h0007);
    check("p2_halted", {31'd0, halted}, 32'd1);
    check_halt(12'h10A, 16'h0007);

`ifdef ACCUM_INDIRECT_EN
    // ---------------- program 3: indirect load and indirect jump
    rst_n = 1'b0;
    @(negedge clk);
    mem_load(12'h020, 16'h0030);
    mem_load(12'h030, 16'hBEEF);
    mem_load(12'h021, 16'h0140);
    mem_load(12'h100, 16'hB020);
    mem_load(12'h101, 16'hC021);
    mem_load(12'h140, 16'h7000);
    push(12'h101, 16'hBEEF, -1);
    push(12'h140, 16'hBEEF, -1);
    push(12'h140, 16'hBEEF, -1);
    release_reset();
    for (int i = 0; i < 3; i++) check_retire();
    check("p3_halted", {31'd0, halted}, 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
